// File: rtl/simd_ctrl_pkg.sv
// Shared types and defaults for the SIMD pipeline hazard sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package simd_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        RAW_STALL = 2'd1,
        BR_WAIT   = 2'd2,
        FLUSH     = 2'd3
    } hz_state_t;

    localparam int WB_LAT_DEF = 3;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write tracker with two combinational busy read ports.
// Latency: load visible on busy ports the cycle after ld_en; reads are combinational.
// Backpressure: none; loads are accepted every cycle.
module reg_scoreboard
    import simd_ctrl_pkg::*;
#(
    parameter int SEL_BITS = 4,
    parameter int WB_LAT   = WB_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_en,
    input  logic [SEL_BITS-1:0] ld_sel,
    input  logic [SEL_BITS-1:0] rd_sel_a,
    input  logic [SEL_BITS-1:0] rd_sel_b,
    output logic                busy_a,
    output logic                busy_b
);

    localparam int NREG = 1 << SEL_BITS;
    localparam int CW   = (WB_LAT > 1) ? $clog2(WB_LAT) : 1;
    // The issue cycle itself is one of the WB_LAT cycles, so the stored count
    // is the number of cycles still to wait after the issuing cycle. A reader
    // WB_LAT cycles after the writer then sees zero and proceeds.
    localparam logic [CW-1:0] LOAD_VAL = CW'(WB_LAT - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];

    // Next count: issue reload wins over the per-cycle decrement (covers WAW).
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? (cnt_q[i] - ONE) : cnt_q[i];
            if (ld_en && (ld_sel == SEL_BITS'(i))) begin
                cnt_d[i] = LOAD_VAL;
            end
        end
    end

    // Counter array register; reset discards all pending writes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign busy_a = (cnt_q[rd_sel_a] != '0);
    assign busy_b = (cnt_q[rd_sel_b] != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-side sequencer: RAW stalls via scoreboard, branch hold, taken-branch flush.
// Latency: zero added cycles in RUN without hazard; outputs combinational from state/decode.
// Backpressure: fetch_hold freezes fetch/decode while stalled or waiting on a branch.
module pipe_hazard_ctrl
    import simd_ctrl_pkg::*;
#(
    parameter int SEL_BITS   = 4,
    parameter int WB_LAT     = WB_LAT_DEF,
    parameter int BR_TIMEOUT = 8,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    input  logic [SEL_BITS-1:0] dec_rs1,
    input  logic [SEL_BITS-1:0] dec_rs2,
    input  logic                dec_use_rs1,
    input  logic                dec_use_rs2,
    input  logic [SEL_BITS-1:0] dec_rd,
    input  logic                dec_reg_wr,
    input  logic                dec_is_branch,
    input  logic                br_resolved,
    input  logic                br_taken,
    output logic                fetch_hold,
    output logic                issue_bubble,
    output logic                flush_fd,
    output logic                issue,
    output logic [1:0]          state_o,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic                br_timeout
);

    localparam int WAIT_W = (BR_TIMEOUT > 1) ? $clog2(BR_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BR_TIMEOUT - 1);

    hz_state_t          state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               tmo_q, tmo_d;

    logic busy_rs1, busy_rs2, hazard;

    reg_scoreboard #(
        .SEL_BITS (SEL_BITS),
        .WB_LAT   (WB_LAT)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .ld_en    (issue & dec_reg_wr),
        .ld_sel   (dec_rd),
        .rd_sel_a (dec_rs1),
        .rd_sel_b (dec_rs2),
        .busy_a   (busy_rs1),
        .busy_b   (busy_rs2)
    );

    assign hazard = dec_valid & ((dec_use_rs1 & busy_rs1) | (dec_use_rs2 & busy_rs2));

    // Next-state and pipeline control; all controls are quiet while in reset.
    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        tmo_d        = tmo_q;
        fetch_hold   = 1'b0;
        issue_bubble = 1'b0;
        flush_fd     = 1'b0;
        issue        = 1'b0;
        case (state_q)
            RUN, RAW_STALL: begin
                // RAW_STALL re-evaluates the hazard every cycle, so issue
                // resumes in the very cycle the source becomes readable.
                if (hazard) begin
                    fetch_hold   = 1'b1;
                    issue_bubble = 1'b1;
                    state_d      = RAW_STALL;
                end else begin
                    issue   = dec_valid;
                    state_d = (dec_valid && dec_is_branch) ? BR_WAIT : RUN;
                end
            end
            BR_WAIT: begin
                fetch_hold   = 1'b1;
                issue_bubble = 1'b1;
                if (br_resolved) begin
                    state_d = br_taken ? FLUSH : RUN;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = RUN;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            FLUSH: begin
                // fetch_hold stays low so the redirected PC loads this cycle.
                flush_fd     = 1'b1;
                issue_bubble = 1'b1;
                state_d      = RUN;
            end
            default: state_d = RUN;
        endcase
        if (rst) begin
            fetch_hold   = 1'b0;
            issue_bubble = 1'b0;
            flush_fd     = 1'b0;
            issue        = 1'b0;
        end
    end

    // Saturating count of bubble cycles.
    always_comb begin
        stall_d = stall_q;
        if (issue_bubble && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // State, branch wait counter, perf counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            tmo_q   <= tmo_d;
        end
    end

    assign state_o    = state_q;
    assign stall_cnt  = stall_q;
    assign br_timeout = tmo_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed table, hand sequences and a random run
// against a cycle-timestamp reference model.
// Clocked stimulus; inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
module tb_pipe_hazard_ctrl;
    import simd_ctrl_pkg::*;

    localparam int SB  = 4;
    localparam int WBL = 3;
    localparam int BRT = 8;
    localparam int CW  = 6;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst, dec_valid, dec_use_rs1, dec_use_rs2, dec_reg_wr, dec_is_branch;
    logic br_resolved, br_taken;
    logic [SB-1:0] dec_rs1, dec_rs2, dec_rd;
    logic fetch_hold, issue_bubble, flush_fd, issue, br_timeout;
    logic [1:0] state_o;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.SEL_BITS(SB), .WB_LAT(WBL), .BR_TIMEOUT(BRT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd),
        .dec_reg_wr(dec_reg_wr), .dec_is_branch(dec_is_branch), .br_resolved(br_resolved),
        .br_taken(br_taken), .fetch_hold(fetch_hold), .issue_bubble(issue_bubble),
        .flush_fd(flush_fd), .issue(issue), .state_o(state_o), .stall_cnt(stall_cnt),
        .br_timeout(br_timeout)
    );

    // ctl = {fetch_hold, issue_bubble, flush_fd, issue}
    typedef struct {
        logic rst, dv, u1, u2, wr, br, res, tak;
        logic [SB-1:0] rs1, rs2, rd;
        logic [3:0] ctl;
        hz_state_t st;
        int stall;
        logic tmo;
    } vec_t;

    int nvec = 0;
    int nmis = 0;

    function automatic vec_t v(logic rst_i, logic dv, logic [SB-1:0] rs1, logic u1,
                               logic [SB-1:0] rs2, logic u2, logic [SB-1:0] rd, logic wr,
                               logic br, logic res, logic tak, logic [3:0] ctl,
                               hz_state_t st, int stall, logic tmo);
        vec_t r;
        r.rst = rst_i; r.dv = dv; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
        r.rd = rd; r.wr = wr; r.br = br; r.res = res; r.tak = tak;
        r.ctl = ctl; r.st = st; r.stall = stall; r.tmo = tmo;
        return r;
    endfunction

    // Drive one cycle, compare all outputs mid-cycle, then advance past the edge.
    task automatic apply(input vec_t x, input string tag);
        logic [3:0] act;
        rst = x.rst; dec_valid = x.dv; dec_rs1 = x.rs1; dec_use_rs1 = x.u1;
        dec_rs2 = x.rs2; dec_use_rs2 = x.u2; dec_rd = x.rd; dec_reg_wr = x.wr;
        dec_is_branch = x.br; br_resolved = x.res; br_taken = x.tak;
        @(negedge clk);
        act = {fetch_hold, issue_bubble, flush_fd, issue};
        nvec++;
        if (act !== x.ctl || state_o !== 2'(x.st) || int'(stall_cnt) != x.stall
            || br_timeout !== x.tmo) begin
            nmis++;
            $display("FAIL %s vec %0d: ctl=%b want %b state=%0d want %0d stall=%0d want %0d tmo=%b want %b",
                     tag, nvec, act, x.ctl, state_o, x.st, stall_cnt, x.stall, br_timeout, x.tmo);
        end
        @(posedge clk);
        #1;
    endtask

    // Reference model: each register remembers the cycle its pending value
    // becomes readable; a read earlier than that is a hazard.
    int        cyc;
    int        ready_at [1 << SB];
    hz_state_t m_state;
    int        m_bw;
    int        m_stall;
    logic      m_tmo;

    task automatic model_reset();
        for (int i = 0; i < (1 << SB); i++) ready_at[i] = 0;
        m_state = RUN; m_bw = 0; m_stall = 0; m_tmo = 1'b0;
    endtask

    function automatic vec_t model_eval(input vec_t x);
        vec_t r = x;
        bit hz;
        r.st = m_state; r.stall = m_stall; r.tmo = m_tmo; r.ctl = 4'b0000;
        if (!x.rst) begin
            hz = x.dv && ((x.u1 && cyc < ready_at[x.rs1]) || (x.u2 && cyc < ready_at[x.rs2]));
            if (m_state == BR_WAIT)     r.ctl = 4'b1100;
            else if (m_state == FLUSH)  r.ctl = 4'b0110;
            else if (hz)                r.ctl = 4'b1100;
            else                        r.ctl = {3'b000, x.dv};
        end
        return r;
    endfunction

    task automatic model_step(input vec_t x);
        if (x.rst) begin
            model_reset();
        end else begin
            if (x.ctl[0] && x.wr) ready_at[x.rd] = cyc + WBL;
            if (x.ctl[2] && m_stall < SAT) m_stall++;
            case (m_state)
                BR_WAIT: begin
                    m_bw++;
                    if (x.res) m_state = x.tak ? FLUSH : RUN;
                    else if (m_bw == BRT) begin m_state = RUN; m_tmo = 1'b1; end
                end
                FLUSH: m_state = RUN;
                default: begin
                    m_bw = 0;
                    if (x.ctl[2])               m_state = RAW_STALL;
                    else if (x.ctl[0] && x.br)  m_state = BR_WAIT;
                    else                        m_state = RUN;
                end
            endcase
        end
        cyc++;
    endtask

    function automatic vec_t rnd_vec(int rst_odds);
        vec_t r;
        r.rst = (rst_odds > 0) ? ($urandom_range(0, rst_odds - 1) == 0) : 1'b0;
        r.dv  = ($urandom_range(0, 4) != 0);
        r.rs1 = SB'($urandom_range(0, 3)); r.u1 = 1'($urandom);
        r.rs2 = SB'($urandom_range(0, 3)); r.u2 = 1'($urandom);
        r.rd  = SB'($urandom_range(0, 3)); r.wr = ($urandom_range(0, 4) < 3);
        r.br  = ($urandom_range(0, 9) == 0);
        r.res = ($urandom_range(0, 5) == 0); r.tak = 1'($urandom);
        r.ctl = 4'b0; r.st = RUN; r.stall = 0; r.tmo = 1'b0;
        return r;
    endfunction

    vec_t tbl [$];
    vec_t x;

    initial begin
        // Directed table, starting from a freshly reset block.
        tbl.push_back(v(0,1,0,0,0,0,3,1,0,0,0,4'b0001,RUN,0,0));        // write r3
        tbl.push_back(v(0,1,3,1,0,0,4,1,0,0,0,4'b1100,RUN,0,0));        // read r3: bubble
        tbl.push_back(v(0,1,3,1,0,0,4,1,0,0,0,4'b1100,RAW_STALL,1,0));  // bubble
        tbl.push_back(v(0,1,3,1,0,0,4,1,0,0,0,4'b0001,RAW_STALL,2,0));  // 3rd cycle: issue
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,4'b0000,RUN,2,0));
        for (int i = 0; i < 10; i++)                                    // disjoint regs
            tbl.push_back(v(0,1,0,1,1,1,SB'(6 + (i % 8)),1,0,0,0,4'b0001,RUN,2,0));
        tbl.push_back(v(0,1,0,0,0,0,0,0,1,0,0,4'b0001,RUN,2,0));        // taken branch
        tbl.push_back(v(0,1,0,0,0,0,0,0,0,0,0,4'b1100,BR_WAIT,2,0));
        tbl.push_back(v(0,1,0,0,0,0,0,0,0,1,1,4'b1100,BR_WAIT,3,0));
        tbl.push_back(v(0,1,0,0,0,0,0,0,0,0,0,4'b0110,FLUSH,4,0));
        tbl.push_back(v(0,1,0,0,0,0,0,0,0,1,1,4'b0001,RUN,5,0));        // stray resolve
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,4'b0000,RUN,5,0));
        tbl.push_back(v(0,1,0,0,0,0,0,0,1,0,0,4'b0001,RUN,5,0));        // not-taken branch
        tbl.push_back(v(0,1,0,0,0,0,0,0,0,1,0,4'b1100,BR_WAIT,5,0));
        tbl.push_back(v(0,1,0,0,0,0,0,0,0,0,0,4'b0001,RUN,6,0));

        rst = 1'b1; dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0;
        dec_use_rs2 = 0; dec_rd = 0; dec_reg_wr = 0; dec_is_branch = 0;
        br_resolved = 0; br_taken = 0;
        @(posedge clk); #1;

        // Reset with random inputs: controls quiet at once, registers clear after one edge.
        x = rnd_vec(0); x.rst = 1'b1;
        rst = 1'b1; dec_valid = x.dv; dec_rs1 = x.rs1; dec_use_rs1 = x.u1; dec_rs2 = x.rs2;
        dec_use_rs2 = x.u2; dec_rd = x.rd; dec_reg_wr = x.wr; dec_is_branch = x.br;
        br_resolved = x.res; br_taken = x.tak;
        @(negedge clk);
        nvec++;
        if ({fetch_hold, issue_bubble, flush_fd, issue} !== 4'b0000) begin
            nmis++;
            $display("FAIL reset_comb: ctl=%b want 0000", {fetch_hold, issue_bubble, flush_fd, issue});
        end
        @(posedge clk); #1;
        x = rnd_vec(0); x.rst = 1'b1; x.ctl = 4'b0; x.st = RUN; x.stall = 0; x.tmo = 0;
        apply(x, "reset");

        // Random run against the model; last stretch has no reset so the counter saturates.
        cyc = 0;
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            x = model_eval(rnd_vec(40));
            apply(x, "random");
            model_step(x);
        end
        for (int i = 0; i < 400; i++) begin
            x = model_eval(rnd_vec(0));
            apply(x, "random_sat");
            model_step(x);
        end
        nvec++;
        if (int'(stall_cnt) != SAT) begin
            nmis++;
            $display("FAIL stall_sat: stall_cnt=%0d want %0d", stall_cnt, SAT);
        end
        x = rnd_vec(0); x.rst = 1'b1;
        x = model_eval(x);
        apply(x, "random_rst");

        foreach (tbl[i]) apply(tbl[i], "table");

        // WAW: second write to r5 restarts the wait.
        apply(v(0,1,0,0,0,0,5,1,0,0,0,4'b0001,RUN,6,0), "waw");
        apply(v(0,1,0,0,0,0,5,1,0,0,0,4'b0001,RUN,6,0), "waw");
        apply(v(0,1,5,1,0,0,0,0,0,0,0,4'b1100,RUN,6,0), "waw");
        apply(v(0,1,5,1,0,0,0,0,0,0,0,4'b1100,RAW_STALL,7,0), "waw");
        apply(v(0,1,5,1,0,0,0,0,0,0,0,4'b0001,RAW_STALL,8,0), "waw");
        apply(v(0,0,0,0,0,0,0,0,0,0,0,4'b0000,RUN,8,0), "waw");

        // Unresolved branch times out after BRT wait cycles.
        apply(v(0,1,0,0,0,0,0,0,1,0,0,4'b0001,RUN,8,0), "timeout");
        for (int k = 0; k < BRT; k++)
            apply(v(0,1,0,0,0,0,0,0,0,0,0,4'b1100,BR_WAIT,8 + k,0), "timeout");
        apply(v(0,0,0,0,0,0,0,0,0,0,0,4'b0000,RUN,16,1), "timeout");

        // Reset while waiting on a branch that also wrote r7.
        apply(v(0,1,0,0,0,0,7,1,1,0,0,4'b0001,RUN,16,1), "rst_brwait");
        apply(v(1,1,7,1,0,0,0,0,0,0,0,4'b0000,BR_WAIT,16,1), "rst_brwait");
        apply(v(0,1,7,1,0,0,0,0,0,0,0,4'b0001,RUN,0,0), "rst_brwait");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
